// File: rtl/keypad_scanner.sv
// 4x4 active-low matrix keypad scanner with press/release debounce and a one-cycle key strobe.
// Optional auto-repeat while a key is held: define KEYPAD_AUTOREPEAT_EN.
module keypad_scanner #(
  parameter int SCAN_DIVIDE    = 1000,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int REPEAT_SCANS   = 50
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] row_n,
  output logic [3:0] col_n,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int DW = $clog2(SCAN_DIVIDE);
  localparam int CW = (DEBOUNCE_SCANS < 2) ? 1 : $clog2(DEBOUNCE_SCANS + 1);

  if (SCAN_DIVIDE < 4 || DEBOUNCE_SCANS < 1 || REPEAT_SCANS < 1) begin : g_bad_params
    $error("keypad_scanner: SCAN_DIVIDE must be >= 4, DEBOUNCE_SCANS and REPEAT_SCANS >= 1");
  end

  typedef enum logic [1:0] {IDLE, PRESS_DB, HELD, RELEASE_DB} state_t;

  logic [3:0]    row_s1_q, row_s2_q;
  logic [1:0]    col_idx_q, col_idx_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [15:0]   snap_q, snap_d;
  state_t        state_q, state_d;
  logic [3:0]    cand_q, cand_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    col_n_q, col_n_d;
  logic [3:0]    key_code_q, key_code_d;
  logic          key_valid_q, key_valid_d;
  logic          key_held_q, key_held_d;

  logic [15:0]   scan_snap;
  logic [3:0]    scan_code;
  logic          is_empty, is_single, dwell_last, scan_end, accept;
  logic [CW-1:0] cnt_inc;

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int RW = (REPEAT_SCANS < 2) ? 1 : $clog2(REPEAT_SCANS + 1);
  logic [RW-1:0] rep_q, rep_d;
`endif

  always_comb begin
    dwell_d     = dwell_q;
    col_idx_d   = col_idx_q;
    snap_d      = snap_q;
    state_d     = state_q;
    cand_d      = cand_q;
    cnt_d       = cnt_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    key_held_d  = key_held_q;
    accept      = 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
    rep_d       = rep_q;
`endif

    // Snapshot including the column being sampled now, so the scan end sees all 16 keys.
    scan_snap = snap_q;
    for (int r = 0; r < 4; r++) begin
      scan_snap[{r[1:0], col_idx_q}] = ~row_s2_q[r];
    end
    scan_code = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (scan_snap[i]) scan_code = 4'(i);
    end
    is_empty  = (scan_snap == 16'd0);
    is_single = $onehot(scan_snap);
    cnt_inc   = cnt_q + 1'b1;

    dwell_last = (dwell_q == DW'(SCAN_DIVIDE - 1));
    scan_end   = dwell_last && (col_idx_q == 2'd3);
    if (dwell_last) begin
      dwell_d   = '0;
      col_idx_d = col_idx_q + 2'd1;
      snap_d    = scan_snap;
    end else begin
      dwell_d = dwell_q + 1'b1;
    end
    col_n_d = ~(4'b0001 << col_idx_d);

    if (scan_end) begin
      case (state_q)
        IDLE: begin
          if (is_single) begin
            cand_d  = scan_code;
            cnt_d   = CW'(1);
            state_d = PRESS_DB;
            if (DEBOUNCE_SCANS == 1) accept = 1'b1;
          end
        end
        PRESS_DB: begin
          if (is_single && scan_code == cand_q) begin
            cnt_d = cnt_inc;
            if (cnt_inc >= CW'(DEBOUNCE_SCANS)) accept = 1'b1;
          end else if (is_single) begin
            cand_d = scan_code;
            cnt_d  = CW'(1);
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end
        HELD: begin
`ifdef KEYPAD_AUTOREPEAT_EN
          if (is_single && scan_code == key_code_q) begin
            if (rep_q == RW'(REPEAT_SCANS - 1)) begin
              rep_d       = '0;
              key_valid_d = 1'b1;
            end else begin
              rep_d = rep_q + 1'b1;
            end
          end else begin
            rep_d = '0;
          end
`endif
          if (is_empty) begin
            if (DEBOUNCE_SCANS == 1) begin
              state_d    = IDLE;
              key_held_d = 1'b0;
              cnt_d      = '0;
            end else begin
              state_d = RELEASE_DB;
              cnt_d   = CW'(1);
            end
          end
        end
        RELEASE_DB: begin
          if (is_empty) begin
            cnt_d = cnt_inc;
            if (cnt_inc >= CW'(DEBOUNCE_SCANS)) begin
              state_d    = IDLE;
              key_held_d = 1'b0;
              cnt_d      = '0;
            end
          end else begin
            state_d = HELD;
            cnt_d   = '0;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_d   = '0;
`endif
          end
        end
        default: state_d = IDLE;
      endcase

      if (accept) begin
        key_code_d  = scan_code;
        key_valid_d = 1'b1;
        key_held_d  = 1'b1;
        state_d     = HELD;
        cnt_d       = '0;
`ifdef KEYPAD_AUTOREPEAT_EN
        rep_d       = '0;
`endif
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      row_s1_q    <= 4'b1111;
      row_s2_q    <= 4'b1111;
      col_idx_q   <= 2'd0;
      dwell_q     <= '0;
      snap_q      <= 16'd0;
      state_q     <= IDLE;
      cand_q      <= 4'd0;
      cnt_q       <= '0;
      col_n_q     <= 4'b1110;
      key_code_q  <= 4'd0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
      rep_q       <= '0;
`endif
    end else begin
      row_s1_q    <= row_n;
      row_s2_q    <= row_s1_q;
      col_idx_q   <= col_idx_d;
      dwell_q     <= dwell_d;
      snap_q      <= snap_d;
      state_q     <= state_d;
      cand_q      <= cand_d;
      cnt_q       <= cnt_d;
      col_n_q     <= col_n_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
`ifdef KEYPAD_AUTOREPEAT_EN
      rep_q       <= rep_d;
`endif
    end
  end

  assign col_n     = col_n_q;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;

endmodule
